systolic_array_sequencer: RTL

SYSTOLIC_ARRAY_SEQUENCER -- requirements
Module: systolic_array_sequencer

---
 rtl/systolic_array_pkg.sv | 25 ++
 rtl/systolic_array_sequencer_if.sv | 56 +++++
 rtl/systolic_array_seq_counter.sv | 37 +++
 rtl/systolic_array_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared types and sizing for the systolic array sequencer.
// Holds the default dimensions, FSM state encoding and row-kind encoding.
package systolic_array_pkg;

  localparam int SA_N  = 4;
  localparam int SA_DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DRAIN,
    S_WAIT_SPACE,
    S_WEIGHTS,
    S_INPUTS
  } seq_state_e;

  typedef enum logic {
    ROW_INPUT  = 1'b0,
    ROW_WEIGHT = 1'b1
  } row_kind_e;

  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_sequencer_if.sv
// Command, scratchpad-read, array-load and status bundle of the sequencer.
// master = host/scratchpad/array side, slave = sequencer.
interface systolic_array_sequencer_if
  import systolic_array_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW,
  localparam int RW = row_w(N)
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_weights;

  logic          rd_en;
  logic          rd_weight;
  logic [RW-1:0] rd_row;
  logic [N*DW-1:0] rd_data_a;
  logic [N*DW-1:0] rd_data_b;

  logic          weight_en;
  logic          input_en;
  logic          partial_en;
  logic [RW-1:0] row_in_en;
  logic [RW-1:0] row_ps_en;
  logic [N*DW-1:0] array_in;
  logic [N*DW-1:0] array_in_partials;
  logic          drained;
  logic          fifo_has_space;

  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_weights,
    output rd_data_a, rd_data_b,
    output drained, fifo_has_space,
    input  cmd_ready, rd_en, rd_weight, rd_row,
    input  weight_en, input_en, partial_en,
    input  row_in_en, row_ps_en,
    input  array_in, array_in_partials,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_weights,
    input  rd_data_a, rd_data_b,
    input  drained, fifo_has_space,
    output cmd_ready, rd_en, rd_weight, rd_row,
    output weight_en, input_en, partial_en,
    output row_in_en, row_ps_en,
    output array_in, array_in_partials,
    output busy, done
  );

endinterface

// File: rtl/systolic_array_seq_counter.sv
// Loadable up/down row counter wrapping inside 0..N-1.
// tc flags the last row in the current direction.
module systolic_array_seq_counter
  import systolic_array_pkg::*;
#(
  parameter int N = SA_N,
  localparam int RW = row_w(N)
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          load,
  input  logic [RW-1:0] load_val,
  input  logic          en,
  input  logic          down,
  output logic [RW-1:0] cnt,
  output logic          tc
);

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  logic [RW-1:0] nxt;

  always_comb begin
    nxt = cnt;
    if (down) nxt = (cnt == '0) ? LAST : cnt - RW'(1);
    else      nxt = (cnt == LAST) ? '0 : cnt + RW'(1);
  end

  assign tc = down ? (cnt == '0) : (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!nRST)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= nxt;
  end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Streams weight rows then input/partial rows from scratchpad into the array.
// Define SA_SEQ_DOUBLE_BUFFER_EN to gate weight loads on fifo_has_space.
module systolic_array_sequencer
  import systolic_array_pkg::*;
#(
  parameter int N  = SA_N,
  parameter int DW = SA_DW,
  localparam int RW = row_w(N)
) (
  input logic clk,
  input logic nRST,
  systolic_array_sequencer_if.slave bus
);

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  seq_state_e    state;
  logic          gap;
  row_kind_e     kind;
  logic          go_w;
  logic          ld;
  logic [RW-1:0] ld_val;
  logic          cen;
  logic          down;
  logic [RW-1:0] cnt;
  logic          tc;
  logic [N*DW-1:0] a_row;
  logic [N*DW-1:0] b_row;

  assign a_row = bus.rd_data_a;
  assign b_row = bus.rd_data_b;
  assign down  = (state == S_WEIGHTS);

`ifdef SA_SEQ_DOUBLE_BUFFER_EN
  // Shadow weight buffer: no need to wait for the array to empty.
  assign go_w = bus.fifo_has_space;
`else
  assign go_w = bus.drained;
`endif

  systolic_array_seq_counter #(.N(N)) u_cnt (
    .clk      (clk),
    .nRST     (nRST),
    .load     (ld),
    .load_val (ld_val),
    .en       (cen),
    .down     (down),
    .cnt      (cnt),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state <= S_IDLE;
      gap   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.cmd_valid)
          state <= bus.cmd_weights ? S_WAIT_DRAIN : S_WAIT_SPACE;
        S_WAIT_DRAIN: if (go_w)
          state <= S_WEIGHTS;
        S_WAIT_SPACE: if (bus.fifo_has_space) begin
          state <= S_INPUTS;
          gap   <= 1'b0;
        end
        S_WEIGHTS: if (tc) begin
          state <= S_INPUTS;
          gap   <= 1'b0;
        end
        S_INPUTS: begin
          gap <= !gap;
          if (gap && tc) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reads lead drives by one cycle to match the scratchpad latency.
  always_comb begin
    bus.cmd_ready         = !nRST || (state == S_IDLE);
    bus.busy              = nRST && (state != S_IDLE);
    bus.done              = 1'b0;
    bus.rd_en             = 1'b0;
    bus.rd_row            = '0;
    bus.weight_en         = 1'b0;
    bus.input_en          = 1'b0;
    bus.partial_en        = 1'b0;
    bus.row_in_en         = '0;
    bus.row_ps_en         = '0;
    bus.array_in          = '0;
    bus.array_in_partials = '0;
    kind                  = ROW_INPUT;
    ld                    = 1'b0;
    ld_val                = '0;
    cen                   = 1'b0;
    if (nRST) begin
      unique case (state)
        S_WAIT_DRAIN: if (go_w) begin
          bus.rd_en  = 1'b1;
          kind       = ROW_WEIGHT;
          bus.rd_row = LAST;
          ld         = 1'b1;
          ld_val     = LAST;
        end
        S_WAIT_SPACE: if (bus.fifo_has_space) begin
          bus.rd_en = 1'b1;
          ld        = 1'b1;
        end
        S_WEIGHTS: begin
          bus.weight_en = 1'b1;
          bus.row_in_en = cnt;
          bus.array_in  = a_row;
          bus.rd_en     = 1'b1;
          if (tc) begin
            ld = 1'b1;
          end else begin
            kind       = ROW_WEIGHT;
            bus.rd_row = cnt - RW'(1);
            cen        = 1'b1;
          end
        end
        S_INPUTS: begin
          if (!gap) begin
            bus.input_en          = 1'b1;
            bus.partial_en        = 1'b1;
            bus.row_in_en         = cnt;
            bus.row_ps_en         = cnt;
            bus.array_in          = a_row;
            bus.array_in_partials = b_row;
          end else if (tc) begin
            bus.done = 1'b1;
          end else begin
            bus.rd_en  = 1'b1;
            bus.rd_row = cnt + RW'(1);
            cen        = 1'b1;
          end
        end
        default: ;
      endcase
    end
    bus.rd_weight = (kind == ROW_WEIGHT);
  end

endmodule
